regbank_access_ctrl: RTL

Access controller for the 8088 register bank (`register_bank_8088`).
- Shares the bank's single write port between two requesters, A (execution unit) and B (bus interface unit), using round-robin arbitration.
- Passes the two read ports through.
- Runs a self-contained 16-bit XCHG micro-sequence: read both registers, then write each into the other.
- Sits directly in front of the bank and is its only driver.

---
 rtl/regbank_access_ctrl.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/regbank_access_ctrl.sv
// regbank_access_ctrl: sole driver of the 8088 register bank. Arbitrates the
// bank write port between requesters A and B (round robin), passes the read
// ports through, and runs a self-contained 16-bit XCHG micro-sequence.
module regbank_access_ctrl #(
    parameter bit RR_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        a_req,
    output logic        a_ready,
    input  logic [2:0]  a_reg,
    input  logic [15:0] a_data,
    input  logic        a_size,
    input  logic        a_hl,

    input  logic        b_req,
    output logic        b_ready,
    input  logic [2:0]  b_reg,
    input  logic [15:0] b_data,
    input  logic        b_size,
    input  logic        b_hl,

    input  logic        xchg_req,
    input  logic [2:0]  xchg_ra,
    input  logic [2:0]  xchg_rb,
    output logic        xchg_busy,
    output logic        xchg_done,

    input  logic [2:0]  rd_reg1,
    input  logic [2:0]  rd_reg2,
    output logic [15:0] rd_data1,
    output logic [15:0] rd_data2,

    output logic        err_byte,

    output logic        bk_en_write,
    output logic [2:0]  bk_reg_write,
    output logic [15:0] bk_write_data,
    output logic        bk_size,
    output logic        bk_select_high_low,
    output logic [2:0]  bk_reg_read1,
    output logic [2:0]  bk_reg_read2,
    input  logic [15:0] bk_read_data1,
    input  logic [15:0] bk_read_data2
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XRD  = 2'd1,
        XW1  = 2'd2,
        XW2  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        rr_q, rr_d;
    logic [2:0]  ra_q, ra_d;
    logic [2:0]  rb_q, rb_d;
    logic [15:0] cap_a_q, cap_a_d;
    logic [15:0] cap_b_q, cap_b_d;

    // Write-holding register for A/B grants
    logic        wr_en_q, wr_en_d;
    logic [2:0]  wr_reg_q, wr_reg_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic        wr_size_q, wr_size_d;
    logic        wr_hl_q, wr_hl_d;

    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        grant_a;
    logic        grant_b;

    // Round-robin grant; XCHG pre-empts both requesters, nothing granted outside IDLE
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state_q == IDLE && !xchg_req) begin
            if (a_req && b_req) begin
                grant_a = ~rr_q;
                grant_b = rr_q;
            end else begin
                grant_a = a_req;
                grant_b = b_req;
            end
        end
    end

    // Next-state logic for the XCHG sequencer and the write-holding register
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        ra_d      = ra_q;
        rb_d      = rb_q;
        cap_a_d   = cap_a_q;
        cap_b_d   = cap_b_q;
        wr_en_d   = 1'b0;
        wr_reg_d  = wr_reg_q;
        wr_data_d = wr_data_q;
        wr_size_d = wr_size_q;
        wr_hl_d   = wr_hl_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (xchg_req) begin
                    ra_d    = xchg_ra;
                    rb_d    = xchg_rb;
                    state_d = XRD;
                end else if (grant_a || grant_b) begin
                    if (a_req && b_req) begin
                        rr_d = ~rr_q;
                    end
                    wr_reg_d  = grant_a ? a_reg  : b_reg;
                    wr_data_d = grant_a ? a_data : b_data;
                    wr_size_d = grant_a ? a_size : b_size;
                    wr_hl_d   = grant_a ? a_hl   : b_hl;
                    // Byte writes only exist for AL..BH (regs 0-3); others are rejected
                    if (!wr_size_d && wr_reg_d[2]) begin
                        err_d = 1'b1;
                    end else begin
                        wr_en_d = 1'b1;
                    end
                end
            end
            XRD: begin
                cap_a_d = bk_read_data1;
                cap_b_d = bk_read_data2;
                state_d = XW1;
            end
            XW1: begin
                state_d = XW2;
            end
            XW2: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; XCHG addresses are plain data and not reset
    always_ff @(posedge clk) begin
        ra_q <= ra_d;
        rb_q <= rb_d;
        if (!reset_n) begin
            state_q   <= IDLE;
            rr_q      <= RR_INIT;
            cap_a_q   <= 16'h0000;
            cap_b_q   <= 16'h0000;
            wr_en_q   <= 1'b0;
            wr_reg_q  <= 3'd0;
            wr_data_q <= 16'h0000;
            wr_size_q <= 1'b0;
            wr_hl_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            cap_a_q   <= cap_a_d;
            cap_b_q   <= cap_b_d;
            wr_en_q   <= wr_en_d;
            wr_reg_q  <= wr_reg_d;
            wr_data_q <= wr_data_d;
            wr_size_q <= wr_size_d;
            wr_hl_q   <= wr_hl_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Bank write port: XCHG writes come from the captured values, else the holding register
    always_comb begin
        bk_en_write        = wr_en_q;
        bk_reg_write       = wr_reg_q;
        bk_write_data      = wr_data_q;
        bk_size            = wr_size_q;
        bk_select_high_low = wr_hl_q;
        if (state_q == XW1) begin
            bk_en_write        = 1'b1;
            bk_reg_write       = ra_q;
            bk_write_data      = cap_b_q;
            bk_size            = 1'b1;
            bk_select_high_low = 1'b0;
        end else if (state_q == XW2) begin
            bk_en_write        = 1'b1;
            bk_reg_write       = rb_q;
            bk_write_data      = cap_a_q;
            bk_size            = 1'b1;
            bk_select_high_low = 1'b0;
        end
    end

    assign bk_reg_read1 = (state_q == XRD) ? ra_q : rd_reg1;
    assign bk_reg_read2 = (state_q == XRD) ? rb_q : rd_reg2;
    assign rd_data1     = bk_read_data1;
    assign rd_data2     = bk_read_data2;

    assign a_ready   = grant_a;
    assign b_ready   = grant_b;
    assign xchg_busy = (state_q != IDLE);
    assign xchg_done = done_q;
    assign err_byte  = err_q;

endmodule
